// File: rtl/intdiv_seq.sv
// ============================================================================
// intdiv_seq : sequential N-bit signed/unsigned integer divider
//              (non-restoring, one quotient bit per cycle, valid/ready ports)
// Revision 1.0
// ============================================================================
`default_nettype none

module intdiv_seq #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         signed_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] z,
    output logic [N-1:0] r,
    output logic         dbz,
    output logic         ovf
);

    localparam int CW = $clog2(N);
    localparam int PW = N + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        ADJ  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state;
    logic [PW-1:0] pr;
    logic [N-1:0]  qa;
    logic [N-1:0]  dvs;
    logic [CW-1:0] cnt;
    logic          neg_q;
    logic          neg_r;

    logic [N-1:0]  x_mag;
    logic [N-1:0]  y_mag;
    logic [PW-1:0] dx;
    logic [PW-1:0] sh;
    logic [PW-1:0] pr_step;
    logic [PW-1:0] pr_fix;
    logic [N-1:0]  rem;
    logic          is_min_x;

    assign in_ready = (state == IDLE);

    assign x_mag    = (signed_mode && x[N-1]) ? (~x + N'(1)) : x;
    assign y_mag    = (signed_mode && y[N-1]) ? (~y + N'(1)) : y;
    assign is_min_x = (x == {1'b1, {(N-1){1'b0}}});

    // Partial remainder stays in [-|y|, |y|); arithmetic wraps in N+1 bits
    // during the shift, but the post-add/subtract value always fits.
    assign dx      = {1'b0, dvs};
    assign sh      = {pr[N-1:0], qa[N-1]};
    assign pr_step = pr[N] ? (sh + dx) : (sh - dx);
    assign pr_fix  = pr[N] ? (pr + dx) : pr;
    assign rem     = pr_fix[N-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pr        <= '0;
            qa        <= '0;
            dvs       <= '0;
            cnt       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            out_valid <= 1'b0;
            z         <= '0;
            r         <= '0;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (y == '0) begin
                            z         <= '1;
                            r         <= x;
                            dbz       <= 1'b1;
                            ovf       <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else if (signed_mode && is_min_x && (y == '1)) begin
                            z         <= x;
                            r         <= '0;
                            dbz       <= 1'b0;
                            ovf       <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            pr    <= '0;
                            qa    <= x_mag;
                            dvs   <= y_mag;
                            neg_q <= signed_mode && (x[N-1] ^ y[N-1]);
                            neg_r <= signed_mode && x[N-1];
                            cnt   <= CW'(N - 1);
                            state <= ITER;
                        end
                    end
                end
                ITER: begin
                    // Quotient bits shift into qa as dividend bits shift out.
                    pr  <= pr_step;
                    qa  <= {qa[N-2:0], ~pr_step[N]};
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) begin
                        state <= ADJ;
                    end
                end
                ADJ: begin
                    z         <= neg_q ? (~qa + N'(1)) : qa;
                    r         <= neg_r ? (~rem + N'(1)) : rem;
                    dbz       <= 1'b0;
                    ovf       <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        dbz       <= 1'b0;
                        ovf       <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
